print_scan_ctl: RTL and testbench
=================================

Name: print_scan_ctl

Overview:
- Sequences the three cascaded 2-of-5 decade counters (units, tens, hundreds) that scan print-buffer positions during a print-line cycle.
- Clears the counters, presents each position to the hammer/compare logic with a valid/ack handshake, and steps the ring with correctly timed advance levels and decade carries.
- Stops at the programmed line length.
- Checks every digit code for the 2-of-5 property.

Parameters:
- MAX_POS, 132, line length used when i_limit is 0 or exceeds it; legal range 1..199.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  level; sampled in IDLE, begins a scan
- i_abort  in  1  level; returns to IDLE from any state
- i_limit  in  8  binary line length; 0 or >MAX_POS means MAX_POS
- i_dig_u, i_dig_t, i_dig_h  in  5 each  counter outputs, bit order abcde (MSB=a)
- o_set0  out  1  drives set0 of all three counters
- o_adv_u, o_adv_t, o_adv_h  out  1 each  advance levels to the counters
- o_pos_valid  out  1  current position presented
- i_pos_ack  in  1  consumer accepts the position
- o_pos_bcd  out  12  decoded position {h,t,u}, BCD
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse at scan end
- o_check  out  1  sticky 2-of-5 code error

Behaviour:
- Reset (async, active-low): state IDLE; every output 0, including o_check.
- All outputs are registered except o_pos_bcd, which is a combinational decode of the digit inputs.
- Counter timing: a counter loads on the clock edge at which it first samples its advance high, or at which it samples set0 high. The new value is visible the following cycle. Advance must return low for at least one cycle before the next step.
- States:
  - IDLE: wait for i_start. Latch the effective limit L. Clear o_check. Go to CLEAR.
  - CLEAR: o_set0=1 for one cycle. Go to LOAD.
  - LOAD: o_set0=0; counters now read 000. Go to PRESENT.
  - PRESENT: o_pos_valid=1; hold until i_pos_ack.
    - On ack, if the decoded position = L-1: go to DONE.
    - Otherwise: go to STEP.
  - STEP: o_pos_valid=0.
    - o_adv_u=1.
    - o_adv_t=1 if units = 9.
    - o_adv_h=1 if units = 9 and tens = 9.
    - Go to RELEASE.
  - RELEASE: all advances 0 for one cycle. Go to PRESENT.
  - DONE: o_done=1 for one cycle. Go to IDLE.
  - ERROR: all strobes 0; o_check=1. Leave only via i_abort, i_start, or reset.
- Minimum ack-to-next-valid latency is 3 cycles: ack in cycle n, STEP n+1, RELEASE n+2, valid again in n+3.
- The 2-of-5 check is performed on entry to PRESENT, i.e. from LOAD or RELEASE. Any digit without exactly two 1 bits causes a transition to ERROR instead of PRESENT.
- i_abort has priority over every transition:
  - Next state is IDLE; all strobes drop the next cycle.
  - o_check is not cleared by abort.
- i_start while not in IDLE or ERROR is ignored. i_start in ERROR behaves as in IDLE.
- L=1: present position 000, then go to DONE after ack.
- 99→100 rollover: all three advances rise in the same STEP cycle.
- Position 199: never stepped, because MAX_POS ≤ 199.

Optional Feature:
- PRINT_SCAN_CHECK_2OF5_EN
- Defined: validity check and the ERROR state as described above.
- Undefined: no check is made, the ERROR state is absent, o_check is tied 0, and invalid codes decode to 0.

Decomposition:
- Package print_scan_pkg holds:
  - the ten 2-of-5 code constants, abcde order: 0=00011, 1=10010, 2=10001, 3=01001, 4=11000, 5=10100, 6=01100, 7=01010, 8=00110, 9=00101
  - the state enum
  - the MAX_POS default
- Sub-module two_of_five_decode: 5-bit code → 4-bit BCD plus valid flag. It is instantiated three times.

Test Plan:
- Counter models attached, i_limit=12, immediate ack → o_pos_bcd steps 000..011. o_done pulses one cycle after the ack of 011. o_busy falls with the return to IDLE.
- Units=9, tens=0 → in STEP, o_adv_u and o_adv_t are both high in the same cycle; the next PRESENT shows 010.
- Position 099 with i_limit=0 (MAX_POS=132) → all three advances assert together; the next PRESENT shows 100. The last valid position is 131.
- Force i_dig_t=00111 before PRESENT → ERROR state, o_check=1, o_pos_valid stays 0. A later i_start clears o_check and restarts from 000.
- i_abort in STEP → next cycle IDLE, all advances 0, o_busy 0. A following i_start issues o_set0 again.
- Assert i_reset_n low mid-RELEASE (asynchronously) → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/print_scan_pkg.sv
//------------------------------------------------------------------------------
// print_scan_pkg : shared constants and state type for the print-line scan
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package print_scan_pkg;

  localparam int c_max_pos_default = 132;

  // Counter digit codes, bit order abcde (a = MSB)
  localparam logic [4:0] c_code_0 = 5'b00011;
  localparam logic [4:0] c_code_1 = 5'b10010;
  localparam logic [4:0] c_code_2 = 5'b10001;
  localparam logic [4:0] c_code_3 = 5'b01001;
  localparam logic [4:0] c_code_4 = 5'b11000;
  localparam logic [4:0] c_code_5 = 5'b10100;
  localparam logic [4:0] c_code_6 = 5'b01100;
  localparam logic [4:0] c_code_7 = 5'b01010;
  localparam logic [4:0] c_code_8 = 5'b00110;
  localparam logic [4:0] c_code_9 = 5'b00101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_STEP    = 3'd4,
    ST_RELEASE = 3'd5,
    ST_DONE    = 3'd6
`ifdef PRINT_SCAN_CHECK_2OF5_EN
    , ST_ERROR = 3'd7
`endif
  } state_t;

endpackage

`default_nettype wire

// File: rtl/two_of_five_decode.sv
//------------------------------------------------------------------------------
// two_of_five_decode : 2-of-5 digit code to BCD; non-table codes give 0, invalid
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module two_of_five_decode
  import print_scan_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [3:0] o_bcd,
  output logic       o_valid
);

  // The ten table entries are exactly the ten 5-bit words with two ones set
  always_comb begin
    o_bcd   = 4'd0;
    o_valid = 1'b1;
    case (i_code)
      c_code_0: o_bcd = 4'd0;
      c_code_1: o_bcd = 4'd1;
      c_code_2: o_bcd = 4'd2;
      c_code_3: o_bcd = 4'd3;
      c_code_4: o_bcd = 4'd4;
      c_code_5: o_bcd = 4'd5;
      c_code_6: o_bcd = 4'd6;
      c_code_7: o_bcd = 4'd7;
      c_code_8: o_bcd = 4'd8;
      c_code_9: o_bcd = 4'd9;
      default:  o_valid = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/print_scan_ctl.sv
//------------------------------------------------------------------------------
// print_scan_ctl : sequences the units/tens/hundreds 2-of-5 counter ring over a
// print line. Option macro: PRINT_SCAN_CHECK_2OF5_EN (code check + ERROR state)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module print_scan_ctl
  import print_scan_pkg::*;
#(
  parameter int MAX_POS = c_max_pos_default
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [7:0]  i_limit,
  input  logic [4:0]  i_dig_u,
  input  logic [4:0]  i_dig_t,
  input  logic [4:0]  i_dig_h,
  output logic        o_set0,
  output logic        o_adv_u,
  output logic        o_adv_t,
  output logic        o_adv_h,
  output logic        o_pos_valid,
  input  logic        i_pos_ack,
  output logic [11:0] o_pos_bcd,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_check
);

  localparam logic [7:0] c_max_pos = 8'(MAX_POS);

  state_t     r_state;
  logic [7:0] r_limit;
  logic       r_set0, r_adv_u, r_adv_t, r_adv_h;
  logic       r_pos_valid, r_busy, r_done;

  logic [3:0] w_bcd_u, w_bcd_t, w_bcd_h;
  logic       w_ok_u, w_ok_t, w_ok_h;
  logic [3:0] w_dig_u, w_dig_t, w_dig_h;
  logic [9:0] w_pos;
  logic       w_last;
  logic [7:0] w_eff_limit;

  two_of_five_decode u_dec_u (.i_code(i_dig_u), .o_bcd(w_bcd_u), .o_valid(w_ok_u));
  two_of_five_decode u_dec_t (.i_code(i_dig_t), .o_bcd(w_bcd_t), .o_valid(w_ok_t));
  two_of_five_decode u_dec_h (.i_code(i_dig_h), .o_bcd(w_bcd_h), .o_valid(w_ok_h));

  assign w_dig_u   = w_ok_u ? w_bcd_u : 4'd0;
  assign w_dig_t   = w_ok_t ? w_bcd_t : 4'd0;
  assign w_dig_h   = w_ok_h ? w_bcd_h : 4'd0;
  assign o_pos_bcd = {w_dig_h, w_dig_t, w_dig_u};

  assign w_pos       = ({6'd0, w_dig_h} * 10'd100) + ({6'd0, w_dig_t} * 10'd10) + {6'd0, w_dig_u};
  assign w_last      = (w_pos == ({2'b00, r_limit} - 10'd1));
  assign w_eff_limit = (i_limit == 8'd0 || i_limit > c_max_pos) ? c_max_pos : i_limit;

`ifdef PRINT_SCAN_CHECK_2OF5_EN
  logic r_check;
  logic w_codes_ok;
  assign w_codes_ok = w_ok_u & w_ok_t & w_ok_h;
  assign o_check    = r_check;
`else
  assign o_check    = 1'b0;
`endif

  // Outputs are registered to reflect the state being entered
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_limit     <= 8'd0;
      r_set0      <= 1'b0;
      r_adv_u     <= 1'b0;
      r_adv_t     <= 1'b0;
      r_adv_h     <= 1'b0;
      r_pos_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef PRINT_SCAN_CHECK_2OF5_EN
      r_check     <= 1'b0;
`endif
    end else begin
      r_set0      <= 1'b0;
      r_adv_u     <= 1'b0;
      r_adv_t     <= 1'b0;
      r_adv_h     <= 1'b0;
      r_pos_valid <= 1'b0;
      r_done      <= 1'b0;
      if (i_abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
`ifdef PRINT_SCAN_CHECK_2OF5_EN
          ST_IDLE, ST_ERROR: begin
`else
          ST_IDLE: begin
`endif
            if (i_start) begin
              r_limit <= w_eff_limit;
`ifdef PRINT_SCAN_CHECK_2OF5_EN
              r_check <= 1'b0;
`endif
              r_state <= ST_CLEAR;
              r_set0  <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          ST_CLEAR: r_state <= ST_LOAD;
          ST_LOAD, ST_RELEASE: begin
`ifdef PRINT_SCAN_CHECK_2OF5_EN
            if (!w_codes_ok) begin
              r_state <= ST_ERROR;
              r_check <= 1'b1;
            end else begin
              r_state     <= ST_PRESENT;
              r_pos_valid <= 1'b1;
            end
`else
            r_state     <= ST_PRESENT;
            r_pos_valid <= 1'b1;
`endif
          end
          ST_PRESENT: begin
            if (!i_pos_ack) begin
              r_pos_valid <= 1'b1;
            end else if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_STEP;
              r_adv_u <= 1'b1;
              r_adv_t <= (w_dig_u == 4'd9);
              r_adv_h <= (w_dig_u == 4'd9) && (w_dig_t == 4'd9);
            end
          end
          ST_STEP: r_state <= ST_RELEASE;
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_set0      = r_set0;
  assign o_adv_u     = r_adv_u;
  assign o_adv_t     = r_adv_t;
  assign o_adv_h     = r_adv_h;
  assign o_pos_valid = r_pos_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_print_scan_ctl.sv
//------------------------------------------------------------------------------
// tb_print_scan_ctl : randomized self-checking bench with 2-of-5 counter models
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_print_scan_ctl;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic        i_pos_ack = 1'b0;
  logic [7:0]  i_limit = 8'd0;
  logic [4:0]  i_dig_u, i_dig_t, i_dig_h;
  logic        o_set0, o_adv_u, o_adv_t, o_adv_h, o_pos_valid;
  logic        o_busy, o_done, o_check;
  logic [11:0] o_pos_bcd;

  int   n_total = 0;
  int   n_bad = 0;
  int   cnt_u = 3, cnt_t = 7, cnt_h = 1;
  logic pu = 1'b0, pt = 1'b0, ph = 1'b0;
  logic force_t = 1'b0;

  print_scan_ctl dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_abort(i_abort),
    .i_limit(i_limit), .i_dig_u(i_dig_u), .i_dig_t(i_dig_t), .i_dig_h(i_dig_h),
    .o_set0(o_set0), .o_adv_u(o_adv_u), .o_adv_t(o_adv_t), .o_adv_h(o_adv_h),
    .o_pos_valid(o_pos_valid), .i_pos_ack(i_pos_ack), .o_pos_bcd(o_pos_bcd),
    .o_busy(o_busy), .o_done(o_done), .o_check(o_check)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [4:0] code_of(input int d);
    case (d)
      0: return 5'b00011;  1: return 5'b10010;  2: return 5'b10001;
      3: return 5'b01001;  4: return 5'b11000;  5: return 5'b10100;
      6: return 5'b01100;  7: return 5'b01010;  8: return 5'b00110;
      9: return 5'b00101;  default: return 5'b00000;
    endcase
  endfunction

  assign i_dig_u = code_of(cnt_u);
  assign i_dig_t = force_t ? 5'b00111 : code_of(cnt_t);
  assign i_dig_h = code_of(cnt_h);

  // Decade counters: clear on set0, step once per rising advance level
  always @(posedge i_clk) begin
    if (o_set0) begin
      cnt_u <= 0; cnt_t <= 0; cnt_h <= 0;
    end else begin
      if (o_adv_u && !pu) cnt_u <= (cnt_u + 1) % 10;
      if (o_adv_t && !pt) cnt_t <= (cnt_t + 1) % 10;
      if (o_adv_h && !ph) cnt_h <= (cnt_h + 1) % 10;
    end
    pu <= o_adv_u; pt <= o_adv_t; ph <= o_adv_h;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] bcd_of(input int p);
    return {4'(p / 100), 4'((p / 10) % 10), 4'(p % 10)};
  endfunction

  // One complete scan; reset_at >= 0 asserts reset asynchronously in that RELEASE
  task automatic run_scan(input int lim_in, input int reset_at);
    int eff;
    eff = (lim_in == 0 || lim_in > 132) ? 132 : lim_in;
    i_limit = 8'(lim_in);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check_val("clear_set0", o_set0, 1'b1);
    check_val("clear_busy", o_busy, 1'b1);
    check_val("clear_check", o_check, 1'b0);
    @(negedge i_clk);
    check_val("load_set0", o_set0, 1'b0);
    for (int p = 0; p < eff; p++) begin
      @(negedge i_clk);
      check_val("valid_latency", o_pos_valid, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge i_clk);
        check_val("valid_hold", o_pos_valid, 1'b1);
      end
      check_val("pos_bcd", o_pos_bcd, bcd_of(p));
      i_pos_ack = 1'b1;
      i_start = (p == 1);
      @(negedge i_clk);
      i_pos_ack = 1'b0;
      i_start = 1'b0;
      if (p == eff - 1) begin
        check_val("done_pulse", {o_done, o_pos_valid, o_adv_u}, 3'b100);
        @(negedge i_clk);
        check_val("done_end", {o_done, o_busy}, 2'b00);
      end else begin
        check_val("step_adv", {o_adv_u, o_adv_t, o_adv_h, o_pos_valid},
                  {1'b1, ((p + 1) % 10 == 0), ((p + 1) % 100 == 0), 1'b0});
        @(negedge i_clk);
        check_val("release_adv", {o_adv_u, o_adv_t, o_adv_h, o_pos_valid}, 4'b0000);
        if (p == reset_at) begin
          #2 i_reset_n = 1'b0;
          #1 check_val("async_reset",
                       {o_set0, o_adv_u, o_adv_t, o_adv_h, o_pos_valid, o_busy, o_done, o_check},
                       8'h00);
          return;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge i_clk);
    @(negedge i_clk);
    check_val("reset_outs",
              {o_set0, o_adv_u, o_adv_t, o_adv_h, o_pos_valid, o_busy, o_done, o_check}, 8'h00);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    check_val("idle_outs", {o_set0, o_pos_valid, o_busy, o_done}, 4'h0);

    run_scan(12, -1);
    run_scan(1, -1);
    run_scan(0, -1);
    run_scan(150, -1);
    repeat (4) run_scan(int'($urandom_range(1, 45)), -1);

    // Abort while stepping, then a fresh start must clear the ring again
    i_limit = 8'd20;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check_val("abort_valid", o_pos_valid, 1'b1);
    i_pos_ack = 1'b1;
    @(negedge i_clk);
    i_pos_ack = 1'b0;
    check_val("abort_step", o_adv_u, 1'b1);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    check_val("abort_idle", {o_adv_u, o_adv_t, o_adv_h, o_pos_valid, o_busy}, 5'b00000);
    run_scan(3, -1);

    // Invalid code decodes to zero in both builds
    force_t = 1'b1;
    @(negedge i_clk);
    check_val("bad_code_decode", o_pos_bcd[7:4], 4'd0);
    check_val("bad_code_idle_check", o_check, 1'b0);
`ifdef PRINT_SCAN_CHECK_2OF5_EN
    i_limit = 8'd5;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check_val("err_entry", {o_check, o_pos_valid, o_busy}, 3'b101);
    repeat (3) @(negedge i_clk);
    check_val("err_hold", {o_check, o_pos_valid}, 2'b10);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    check_val("err_abort", {o_check, o_busy}, 2'b10);
`endif
    force_t = 1'b0;
    run_scan(4, -1);

    run_scan(20, 7);
    @(negedge i_clk);
    check_val("reset_hold", {o_busy, o_pos_valid, o_adv_u}, 3'b000);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    run_scan(5, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
